rv32i_multicycle_core: RTL and testbench
========================================

// Module: rv32i_multicycle_core
// PURPOSE
//  Multicycle RV32I integer core with one unified instruction/data memory port.
//  Fetches, decodes and executes one instruction at a time and keeps a 32x32 register file.
//  Halts on EBREAK. Sits between the system top and an external combinational-read memory.
// PARAMETERS
//  NREGISTER   32            number of architectural registers; x0 is hardwired to zero
//  RESET_PC    32'h00000000  PC loaded on reset
// PORTS
//  clk       in   1   single clock; all state updates on posedge
//  resetn    in   1   reset: synchronous, active-high (asserted = 1 resets core on posedge clk)
//  address   out  32  byte address for fetch/load/store; always word-aligned
//  data_out  out  32  store data to memory; valid when we=1
//  data_in   in   32  read data from memory; combinational from address, same cycle
//  we        out  1   memory write enable; level, one cycle per store
// BEHAVIOUR
//  - Reset: PC=RESET_PC, state=FETCH, instr=0, we=0, address=RESET_PC,
//    data_out=0, all registers=0. Reset mid-instruction aborts it; no reg/mem write occurs.
//  - FSM states: FETCH, DECODE, EXEC, MEMADR, MEMRD, MEMWB, MEMWR, ALUWB, BRANCH, JUMP, HALT.
//  - FETCH: address=PC. On the posedge: instr<=data_in, PC<=PC+4, old PC saved.
//  - DECODE: read rs1/rs2 and build the immediate (I/S/B/U/J).
//    Branch target = oldPC+immB, computed here.
//  - Instruction latencies (cycles): OP/OP-IMM/LUI/AUIPC = 4 (FETCH,DECODE,EXEC,ALUWB);
//    LW = 5 (FETCH,DECODE,MEMADR,MEMRD,MEMWB); SW = 4 (..,MEMADR,MEMWR);
//    branch = 3 (..,BRANCH); JAL/JALR = 3 (..,JUMP, which writes rd=oldPC+4 and sets PC).
//  - Register write: rd is written on the posedge ending ALUWB/MEMWB/JUMP.
//    The new value is visible from the following negedge. Writes to x0 are discarded.
//    Only these states enable a register write.
//  - ALU: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, plus the immediate forms.
//    Shift amount = low 5 bits. Arithmetic wraps mod 2^32.
//    SLT is signed, SLTU is unsigned. SRAI/SRLI are selected by instr[30].
//  - Branches: BEQ, BNE, BLT, BGE (signed), BLTU, BGEU (unsigned).
//    Taken: PC<=oldPC+immB. Not taken: PC stays oldPC+4.
//  - JALR target = (rs1+immI) & ~1. Targets are not alignment-checked.
//  - Loads/stores: only LW/SW supported. Address = rs1+imm with bits[1:0] forced to 0.
//    Sub-word loads/stores execute as word ops.
//  - MEMWR: address=ea, data_out=rs2, we=1 for exactly that cycle; we=0 in every other state.
//  - FENCE and ECALL execute as NOPs (3 cycles). Unknown opcodes execute as NOPs.
//  - EBREAK (32'h00100073): on decode enter HALT. In HALT: PC frozen, no writes, we=0,
//    instr held at 32'h00100073 until reset.
//  - Reads of the register being written in the same cycle return the old value (no bypass).
// TESTING
//  - Reset: hold resetn=1 for 2 edges -> address=0, we=0, all regs 0.
//    Release -> first fetch from 0.
//  - ADDI x1,x0,5; ADDI x2,x1,-7 -> x1=5, x2=0xFFFFFFFE.
//    Each write occurs 4 cycles apart; x0 write attempt leaves x0=0.
//  - SW x2,8(x0); LW x3,8(x0) -> we=1 one cycle with address=8, data_out=0xFFFFFFFE;
//    x3=0xFFFFFFFE after 5 cycles.
//  - BLT x2,x1,+8 (taken, signed) skips next instr.
//    BLTU x2,x1,+8 (not taken) falls through. PC values checked.
//  - JAL x5,+12 at PC=0x20 -> x5=0x24, PC=0x2C. JALR x0,0(x5) -> PC=0x24.
//  - EBREAK at 0x30 -> HALT; 10 further cycles: no register write, we=0, address constant.

Source files
------------

// File: rtl/rv32i_multicycle_core.sv
`default_nettype none
// ============================================================================
//  Module   : rv32i_multicycle_core
//  Brief    : Multicycle RV32I integer core with one unified combinational-read
//             instruction/data memory port. One instruction in flight at a
//             time, 32x32 register file, halts on EBREAK until reset.
//  Revision : 1.0 - initial release
// ============================================================================
module rv32i_multicycle_core #(
    parameter int          NREGISTER = 32,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        resetn,
    output logic [31:0] address,
    output logic [31:0] data_out,
    input  logic [31:0] data_in,
    output logic        we
);

    localparam logic [6:0]  OPC_OP     = 7'h33;
    localparam logic [6:0]  OPC_OPIMM  = 7'h13;
    localparam logic [6:0]  OPC_LUI    = 7'h37;
    localparam logic [6:0]  OPC_AUIPC  = 7'h17;
    localparam logic [6:0]  OPC_LOAD   = 7'h03;
    localparam logic [6:0]  OPC_STORE  = 7'h23;
    localparam logic [6:0]  OPC_BRANCH = 7'h63;
    localparam logic [6:0]  OPC_JAL    = 7'h6F;
    localparam logic [6:0]  OPC_JALR   = 7'h67;
    localparam logic [31:0] EBREAK     = 32'h0010_0073;

    typedef enum logic [3:0] {
        FETCH, DECODE, EXEC, MEMADR, MEMRD, MEMWB, MEMWR, ALUWB, BRANCH, JUMP, HALT
    } state_t;

    state_t      state, next_state;
    logic [31:0] pc, old_pc, instr, rs1_val, rs2_val, imm, branch_target, alu_out, mdr;
    logic [31:0] regs [NREGISTER];

    logic [6:0]  opcode;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sel;
    logic [31:0] alu_a, alu_b, alu_res, jump_target;
    logic        is_alu, taken;

    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign funct3 = instr[14:12];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'h000};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    assign is_alu = (opcode == OPC_OP) || (opcode == OPC_OPIMM) ||
                    (opcode == OPC_LUI) || (opcode == OPC_AUIPC);

    // Immediate format selection by opcode
    always_comb begin
        imm_sel = imm_i;
        case (opcode)
            OPC_STORE:          imm_sel = imm_s;
            OPC_LUI, OPC_AUIPC: imm_sel = imm_u;
            OPC_JAL:            imm_sel = imm_j;
            default:            imm_sel = imm_i;
        endcase
    end

    // ALU: LUI/AUIPC reuse the adder with a zero or PC first operand
    always_comb begin
        alu_a   = (opcode == OPC_AUIPC) ? old_pc : ((opcode == OPC_LUI) ? 32'h0 : rs1_val);
        alu_b   = (opcode == OPC_OP) ? rs2_val : imm;
        alu_res = alu_a + alu_b;
        if (opcode == OPC_OP || opcode == OPC_OPIMM) begin
            case (funct3)
                3'd0: alu_res = (opcode == OPC_OP && instr[30]) ? alu_a - alu_b : alu_a + alu_b;
                3'd1: alu_res = alu_a << alu_b[4:0];
                3'd2: alu_res = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
                3'd3: alu_res = (alu_a < alu_b) ? 32'd1 : 32'd0;
                3'd4: alu_res = alu_a ^ alu_b;
                3'd5: alu_res = instr[30] ? ($signed(alu_a) >>> alu_b[4:0]) : (alu_a >> alu_b[4:0]);
                3'd6: alu_res = alu_a | alu_b;
                default: alu_res = alu_a & alu_b;
            endcase
        end
    end

    // Branch condition and jump target from the operands latched in DECODE
    always_comb begin
        case (funct3)
            3'd0:    taken = (rs1_val == rs2_val);
            3'd1:    taken = (rs1_val != rs2_val);
            3'd4:    taken = ($signed(rs1_val) < $signed(rs2_val));
            3'd5:    taken = ($signed(rs1_val) >= $signed(rs2_val));
            3'd6:    taken = (rs1_val < rs2_val);
            3'd7:    taken = (rs1_val >= rs2_val);
            default: taken = 1'b0;
        endcase
        jump_target = (opcode == OPC_JALR) ? ((rs1_val + imm) & 32'hFFFF_FFFE) : (old_pc + imm);
    end

    // State register
    always_ff @(posedge clk) begin
        if (resetn) state <= FETCH;
        else        state <= next_state;
    end

    // Next-state logic and memory port outputs
    always_comb begin
        next_state = state;
        address    = {pc[31:2], 2'b00};
        data_out   = 32'h0;
        we         = 1'b0;
        case (state)
            FETCH:  next_state = DECODE;
            DECODE: begin
                if (instr == EBREAK) next_state = HALT;
                else begin
                    case (opcode)
                        OPC_LOAD, OPC_STORE: next_state = MEMADR;
                        OPC_BRANCH:          next_state = BRANCH;
                        OPC_JAL, OPC_JALR:   next_state = JUMP;
                        default:             next_state = EXEC;  // ALU ops and NOPs
                    endcase
                end
            end
            EXEC:   next_state = is_alu ? ALUWB : FETCH;
            MEMADR: next_state = (opcode == OPC_LOAD) ? MEMRD : MEMWR;
            MEMRD: begin
                address    = alu_out;
                next_state = MEMWB;
            end
            MEMWR: begin
                address    = alu_out;
                data_out   = rs2_val;
                we         = 1'b1;
                next_state = FETCH;
            end
            HALT:    next_state = HALT;
            default: next_state = FETCH;
        endcase
    end

    // Datapath registers and register file; only ALUWB/MEMWB/JUMP write rd
    always_ff @(posedge clk) begin
        if (resetn) begin
            pc            <= RESET_PC;
            old_pc        <= RESET_PC;
            instr         <= 32'h0;
            rs1_val       <= 32'h0;
            rs2_val       <= 32'h0;
            imm           <= 32'h0;
            branch_target <= 32'h0;
            alu_out       <= 32'h0;
            mdr           <= 32'h0;
            for (int i = 0; i < NREGISTER; i++) regs[i] <= 32'h0;
        end else begin
            case (state)
                FETCH: begin
                    instr  <= data_in;
                    old_pc <= pc;
                    pc     <= pc + 32'd4;
                end
                DECODE: begin
                    rs1_val       <= regs[rs1];
                    rs2_val       <= regs[rs2];
                    imm           <= imm_sel;
                    branch_target <= old_pc + imm_b;
                end
                EXEC:   alu_out <= alu_res;
                MEMADR: alu_out <= (rs1_val + imm) & 32'hFFFF_FFFC;
                MEMRD:  mdr <= data_in;
                MEMWB:  if (rd != 5'd0) regs[rd] <= mdr;
                ALUWB:  if (rd != 5'd0) regs[rd] <= alu_out;
                BRANCH: if (taken) pc <= branch_target;
                JUMP: begin
                    if (rd != 5'd0) regs[rd] <= old_pc + 32'd4;
                    pc <= jump_target;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rv32i_multicycle_core.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rv32i_multicycle_core
//  Brief    : Self-checking bench for rv32i_multicycle_core. An instruction-
//             level reference model predicts fetch addresses, per-instruction
//             latency, store traffic and final register contents.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rv32i_multicycle_core;

    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic [31:0] address, data_out, data_in;
    logic        we;

    logic [31:0] mem     [1024];
    logic [31:0] ref_mem [1024];
    logic [31:0] ref_regs[32];
    logic [31:0] ref_pc;
    int          total = 0;
    int          bad = 0;

    localparam logic [31:0] EBREAK = 32'h0010_0073;

    rv32i_multicycle_core #(.NREGISTER(32), .RESET_PC(32'h0)) dut (
        .clk      (clk),
        .resetn   (resetn),
        .address  (address),
        .data_out (data_out),
        .data_in  (data_in),
        .we       (we)
    );

    assign data_in = mem[address[11:2]];

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ---------------- instruction encoders ----------------
    function automatic logic [31:0] enc_i(input logic [11:0] im, input logic [4:0] r1,
                                          input logic [2:0] f3, input logic [4:0] rdx, input logic [6:0] op);
        return {im, r1, f3, rdx, op};
    endfunction
    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] r2, input logic [4:0] r1,
                                          input logic [2:0] f3, input logic [4:0] rdx);
        return {f7, r2, r1, f3, rdx, 7'h33};
    endfunction
    function automatic logic [31:0] enc_s(input logic [11:0] im, input logic [4:0] r2, input logic [4:0] r1);
        return {im[11:5], r2, r1, 3'b010, im[4:0], 7'h23};
    endfunction
    function automatic logic [31:0] enc_b(input logic [12:0] im, input logic [4:0] r2, input logic [4:0] r1,
                                          input logic [2:0] f3);
        return {im[12], im[10:5], r2, r1, f3, im[4:1], im[11], 7'h63};
    endfunction
    function automatic logic [31:0] enc_j(input logic [20:0] im, input logic [4:0] rdx);
        return {im[20], im[10:1], im[11], im[19:12], rdx, 7'h6F};
    endfunction
    function automatic logic [31:0] enc_u(input logic [19:0] im, input logic [4:0] rdx, input logic [6:0] op);
        return {im, rdx, op};
    endfunction

    // ---------------- reference model ----------------
    function automatic logic [31:0] ref_alu(input logic [2:0] f3, input logic alt,
                                            input logic [31:0] a, input logic [31:0] b);
        int sh;
        sh = int'(b % 32);
        case (f3)
            3'd0: return alt ? a - b : a + b;
            3'd1: return a << sh;
            3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3: return (a < b) ? 32'd1 : 32'd0;
            3'd4: return a ^ b;
            3'd5: return alt ? 32'($signed(a) >>> sh) : a >> sh;
            3'd6: return a | b;
            default: return a & b;
        endcase
    endfunction

    task automatic iss_step(output int cyc, output bit st, output logic [31:0] sa,
                            output logic [31:0] sd, output bit halt);
        logic [31:0] ins, a, b, res, npc, i_imm, s_imm, b_imm, u_imm, j_imm;
        logic [2:0]  f3;
        bit          wr, tk;
        ins   = ref_mem[ref_pc[11:2]];
        f3    = ins[14:12];
        a     = ref_regs[ins[19:15]];
        b     = ref_regs[ins[24:20]];
        i_imm = {{20{ins[31]}}, ins[31:20]};
        s_imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
        b_imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        u_imm = {ins[31:12], 12'h000};
        j_imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        npc = ref_pc + 32'd4;
        res = 32'h0; wr = 0; st = 0; sa = 32'h0; sd = 32'h0; halt = 0; cyc = 3;
        if (ins == EBREAK) begin
            halt = 1; cyc = 2;
        end else begin
            case (ins[6:0])
                7'h13: begin res = ref_alu(f3, (f3 == 3'd5) && ins[30], a, i_imm); wr = 1; cyc = 4; end
                7'h33: begin res = ref_alu(f3, ins[30], a, b); wr = 1; cyc = 4; end
                7'h37: begin res = u_imm; wr = 1; cyc = 4; end
                7'h17: begin res = ref_pc + u_imm; wr = 1; cyc = 4; end
                7'h03: begin res = ref_mem[((a + i_imm) / 4) % 1024]; wr = 1; cyc = 5; end
                7'h23: begin
                    sa = (a + s_imm) & 32'hFFFF_FFFC; sd = b; st = 1; cyc = 4;
                    ref_mem[(sa / 4) % 1024] = b;
                end
                7'h63: begin
                    case (f3)
                        3'd0: tk = (a == b);
                        3'd1: tk = (a != b);
                        3'd4: tk = ($signed(a) < $signed(b));
                        3'd5: tk = !($signed(a) < $signed(b));
                        3'd6: tk = (a < b);
                        3'd7: tk = !(a < b);
                        default: tk = 0;
                    endcase
                    if (tk) npc = ref_pc + b_imm;
                end
                7'h6F: begin res = ref_pc + 32'd4; wr = 1; npc = ref_pc + j_imm; end
                7'h67: begin res = ref_pc + 32'd4; wr = 1; npc = (a + i_imm) & 32'hFFFF_FFFE; end
                default: ;
            endcase
        end
        if (wr && ins[11:7] != 5'd0) ref_regs[ins[11:7]] = res;
        if (!halt) ref_pc = npc;
    endtask

    // ---------------- sequencing helpers ----------------
    task automatic do_reset(input string name);
        @(negedge clk);
        resetn = 1'b1;
        repeat (2) @(negedge clk);
        check({name, "_addr"}, address, 32'h0);
        check({name, "_we"}, 32'(we), 32'd0);
        check({name, "_dout"}, data_out, 32'h0);
        for (int i = 0; i < 32; i++) check({name, "_reg_zero"}, dut.regs[i], 32'h0);
        resetn = 1'b0;
    endtask

    task automatic run_program(input string name);
        int          cyc;
        bit          st, halted;
        logic [31:0] sa, sd, hold;
        for (int i = 0; i < 1024; i++) ref_mem[i] = mem[i];
        for (int i = 0; i < 32; i++) ref_regs[i] = 32'h0;
        ref_pc = 32'h0;
        halted = 0;
        for (int n = 0; n < 300 && !halted; n++) begin
            check({name, "_fetch_addr"}, address, ref_pc & 32'hFFFF_FFFC);
            check({name, "_fetch_we"}, 32'(we), 32'd0);
            iss_step(cyc, st, sa, sd, halted);
            if (halted) begin
                @(negedge clk);
                check({name, "_decode_we"}, 32'(we), 32'd0);
                @(negedge clk);
                hold = address;
                for (int k = 0; k < 10; k++) begin
                    @(negedge clk);
                    check({name, "_halt_we"}, 32'(we), 32'd0);
                    check({name, "_halt_addr"}, address, hold);
                end
            end else begin
                for (int c = 1; c < cyc; c++) begin
                    @(negedge clk);
                    if (st && c == cyc - 1) begin
                        check({name, "_st_we"}, 32'(we), 32'd1);
                        check({name, "_st_addr"}, address, sa);
                        check({name, "_st_data"}, data_out, sd);
                    end else begin
                        check({name, "_we"}, 32'(we), 32'd0);
                    end
                    if (we === 1'b1) mem[address[11:2]] = data_out;
                end
                @(negedge clk);
            end
        end
        check({name, "_halted"}, 32'(halted), 32'd1);
        for (int i = 0; i < 32; i++) check({name, "_reg"}, dut.regs[i], ref_regs[i]);
    endtask

    task automatic gen_random();
        logic [2:0] bfs [6];
        bfs = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        mem[0] = enc_i(12'($urandom_range(1, 2047)), 5'd0, 3'd0, 5'd1, 7'h13);
        for (int i = 1; i < 48; i++) begin
            logic [4:0]  rdx, r1, r2;
            logic [2:0]  f3;
            logic [6:0]  f7;
            logic [11:0] im;
            int          kind;
            rdx  = 5'($urandom_range(0, 7));
            r1   = 5'($urandom_range(0, 7));
            r2   = 5'($urandom_range(0, 7));
            f3   = 3'($urandom_range(0, 7));
            kind = int'($urandom_range(0, 9));
            im   = 12'($urandom);
            case (kind)
                0, 1, 2: begin
                    if (f3 == 3'd1) im[11:5] = 7'h00;
                    else if (f3 == 3'd5) im[11:5] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
                    mem[i] = enc_i(im, r1, f3, rdx, 7'h13);
                end
                3, 4: begin
                    f7 = ((f3 == 3'd0 || f3 == 3'd5) && $urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
                    mem[i] = enc_r(f7, r2, r1, f3, rdx);
                end
                5: mem[i] = enc_u(20'($urandom), rdx, ($urandom_range(0, 1) == 1) ? 7'h37 : 7'h17);
                6: mem[i] = enc_s(12'(32'h400 + 4 * $urandom_range(0, 15) + $urandom_range(0, 3)), r2, 5'd0);
                7: mem[i] = enc_i(12'(32'h400 + 4 * $urandom_range(0, 15) + $urandom_range(0, 3)),
                                  5'd0, 3'd2, rdx, 7'h03);
                8: mem[i] = enc_b(13'd8, r2, r1, bfs[$urandom_range(0, 5)]);
                default: mem[i] = enc_j(21'd8, rdx);
            endcase
        end
        mem[48] = EBREAK;
        mem[49] = EBREAK;
    endtask

    // ---------------- directed then randomized sequence ----------------
    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        mem[0]  = enc_i(12'd5,    5'd0, 3'd0, 5'd1, 7'h13);   // ADDI x1,x0,5
        mem[1]  = enc_i(12'hFF9,  5'd1, 3'd0, 5'd2, 7'h13);   // ADDI x2,x1,-7
        mem[2]  = enc_i(12'd9,    5'd0, 3'd0, 5'd0, 7'h13);   // ADDI x0,x0,9
        mem[3]  = enc_s(12'd8,    5'd2, 5'd0);                // SW x2,8(x0)
        mem[4]  = enc_i(12'd8,    5'd0, 3'd2, 5'd3, 7'h03);   // LW x3,8(x0)
        mem[5]  = enc_b(13'd8,    5'd1, 5'd2, 3'd4);          // BLT x2,x1,+8
        mem[6]  = enc_i(12'd1,    5'd0, 3'd0, 5'd4, 7'h13);   // skipped
        mem[7]  = enc_b(13'd8,    5'd1, 5'd2, 3'd6);          // BLTU x2,x1,+8
        mem[8]  = enc_j(21'd12,   5'd5);                      // JAL x5,+12
        mem[9]  = enc_i(12'd12,   5'd5, 3'd0, 5'd5, 7'h13);   // ADDI x5,x5,12
        mem[10] = enc_s(12'h104,  5'd5, 5'd0);                // SW x5,0x104(x0)
        mem[11] = enc_i(12'd0,    5'd5, 3'd0, 5'd0, 7'h67);   // JALR x0,0(x5)
        mem[12] = EBREAK;
        mem[13] = enc_s(12'h108,  5'd1, 5'd0);                // must never run

        do_reset("rst_dir");
        run_program("dir");
        check("dir_x1", dut.regs[1], 32'd5);
        check("dir_x2", dut.regs[2], 32'hFFFF_FFFE);
        check("dir_x3", dut.regs[3], 32'hFFFF_FFFE);
        check("dir_x4", dut.regs[4], 32'h0);
        check("dir_x5", dut.regs[5], 32'h30);
        check("dir_mem8", mem[2], 32'hFFFF_FFFE);
        check("dir_mem104", mem[65], 32'h30);
        check("dir_mem108", mem[66], 32'h0);

        for (int r = 0; r < 4; r++) begin
            gen_random();
            do_reset("rst_rnd");
            if (r == 0) begin
                // abort the first ADDI while it sits in write-back
                repeat (2) @(negedge clk);
                do_reset("rst_abort");
            end
            run_program("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
